// File: rtl/chess_pkg.sv
// Shared chess types: piece codes, square index, move record and start position.
package chess_pkg;

  // Piece code is {color, type[2:0]}
  typedef logic [3:0] piece_t;
  typedef logic [5:0] sq_t;

  localparam logic [2:0] EMPTY   = 3'd0;
  localparam logic [2:0] PAWN    = 3'd1;
  localparam logic [2:0] KNIGHT  = 3'd2;
  localparam logic [2:0] BISHOP  = 3'd3;
  localparam logic [2:0] ROOK    = 3'd4;
  localparam logic [2:0] QUEEN   = 3'd5;
  localparam logic [2:0] KING    = 3'd6;
  localparam logic [2:0] ILLEGAL = 3'd7;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef struct packed {
    sq_t    from;
    sq_t    to;
    piece_t promo;
  } move_t;

  // Whole board, element index = row*8+col
  typedef logic [63:0][3:0] board_t;

  // Back rank piece type for a given column: R N B Q K B N R
  function automatic logic [2:0] back_rank(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: back_rank = ROOK;
      3'd1, 3'd6: back_rank = KNIGHT;
      3'd2, 3'd5: back_rank = BISHOP;
      3'd3:       back_rank = QUEEN;
      default:    back_rank = KING;
    endcase
  endfunction

  // Row 0 is the black back rank, row 7 the white one
  function automatic board_t start_board();
    board_t b;
    b = '0;
    for (int s = 0; s < 64; s++) begin
      logic [2:0] row;
      logic [2:0] col;
      row = 3'(s / 8);
      col = 3'(s % 8);
      case (row)
        3'd0:    b[s] = {BLACK, back_rank(col)};
        3'd1:    b[s] = {BLACK, PAWN};
        3'd6:    b[s] = {WHITE, PAWN};
        3'd7:    b[s] = {WHITE, back_rank(col)};
        default: b[s] = {WHITE, EMPTY};
      endcase
    end
    return b;
  endfunction

  localparam board_t START_POS = start_board();

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of move records; push and pop may coincide, flush empties it.
module move_fifo
  import chess_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  push,
  input  move_t din,
  input  logic  pop,
  output move_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  move_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count guards reads
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush wins over a same-cycle push
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/board_update_sched.sv
// Board-state owner: queues moves from game logic and commits them, or a
// start-position reload, only while the display is in vertical blanking.
module board_update_sched
  import chess_pkg::*;
#(
  parameter int         QDEPTH  = 4,
  parameter logic [9:0] VACTIVE = 10'd480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vcnt,
  input  logic       new_game,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [5:0] mv_from,
  input  logic [5:0] mv_to,
  input  logic [3:0] mv_promo,
  input  logic [5:0] rd_sq,
  output logic [3:0] rd_piece,
  output logic       applied,
  output logic       err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RELOAD = 2'd1;
  localparam logic [1:0] S_LATCH  = 2'd2;
  localparam logic [1:0] S_WRITE  = 2'd3;

  logic [1:0] state;
  board_t     board;
  logic       reload_pend;
  move_t      mv_q;
  piece_t     piece_q;

  logic       in_blank;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;
  move_t      fifo_din;
  move_t      fifo_dout;
  logic       move_ok;

  assign in_blank   = (vcnt >= VACTIVE);
  assign mv_ready   = ~fifo_full;
  assign fifo_push  = mv_valid & mv_ready;
  assign fifo_din   = '{from: mv_from, to: mv_to, promo: mv_promo};
  // Pending reload takes precedence, so no pop in that cycle
  assign fifo_pop   = (state == S_IDLE) & in_blank & ~reload_pend & ~fifo_empty;
  assign fifo_flush = (state == S_RELOAD);

  assign move_ok = (mv_q.from != mv_q.to) &&
                   (piece_q[2:0] != EMPTY) &&
                   (mv_q.promo[2:0] != ILLEGAL);

  assign rd_piece = board[rd_sq];
  assign busy     = ~fifo_empty | reload_pend | (state != S_IDLE);

  move_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer and board array; moves only start in blanking, but a started
  // move always runs to completion even if vcnt wraps meanwhile
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      board       <= START_POS;
      reload_pend <= 1'b0;
      mv_q        <= '0;
      piece_q     <= '0;
      applied     <= 1'b0;
      err         <= 1'b0;
    end else begin
      applied <= 1'b0;
      err     <= 1'b0;
      if (new_game) reload_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (in_blank && reload_pend) begin
            state <= S_RELOAD;
          end else if (fifo_pop) begin
            mv_q  <= fifo_dout;
            state <= S_LATCH;
          end
        end
        S_RELOAD: begin
          board       <= START_POS;
          // A fresh request in this very cycle stays pending
          reload_pend <= new_game;
          state       <= S_IDLE;
        end
        S_LATCH: begin
          piece_q <= board[mv_q.from];
          state   <= S_WRITE;
        end
        S_WRITE: begin
          if (move_ok) begin
            board[mv_q.to]   <= (mv_q.promo != '0) ? mv_q.promo : piece_q;
            board[mv_q.from] <= {WHITE, EMPTY};
            applied          <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
